// File: rtl/logfbe_frame_rd_arbiter_pkg.sv
// Shared definitions for the log-filterbank-energy FIFO read arbiter:
// FSM encoding, a constant clog2 and parameter legality checks.
package logfbe_frame_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int rd_lat, input int frame_len,
                                      input int addr_width, input int num_req);
    return ((rd_lat == 0) || (rd_lat == 1)) &&
           (frame_len >= 1) && (frame_len <= (1 << addr_width)) &&
           (num_req >= 2) && (num_req <= 8);
  endfunction

endpackage

// File: rtl/logfbe_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping at N. Returns a one-hot grant and its index.
module logfbe_rr_pick
  import logfbe_frame_rd_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    any = |req;
    // Walk the search order backwards so the candidate closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
    if (any) gnt = N'(1) << idx;
  end

endmodule

// File: rtl/logfbe_frame_rd_arbiter.sv
// Frame-granular round-robin arbiter for the LFBE FIFO read port: grants one
// whole buffered frame per request and forwards it tagged with the requester.
module logfbe_frame_rd_arbiter
  import logfbe_frame_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 40,
  parameter int RD_LAT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       fifo_rd_en,
  input  logic                       fifo_empty,
  input  logic [ADDR_WIDTH:0]        fifo_rd_water_level,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [clog2(NUM_REQ)-1:0]  out_sel,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       underrun
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]       LAST_BEAT   = CW'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0] FRAME_WORDS = (ADDR_WIDTH + 1)'(FRAME_LEN);

  if (!params_legal(RD_LAT, FRAME_LEN, ADDR_WIDTH, NUM_REQ)) begin : g_bad_params
    $error("logfbe_frame_rd_arbiter: illegal parameter set");
  end

  arb_state_e          state, state_nxt;
  logic [IW-1:0]       rr_ptr, pick_idx;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;
  logic [CW-1:0]       cnt;
  logic                rd_last, data_take, data_last;

  logfbe_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:
        if (pick_any && (fifo_rd_water_level >= FRAME_WORDS)) state_nxt = ST_READ;
      ST_READ: begin
        fifo_rd_en = ~fifo_empty;
        if (fifo_rd_en && (cnt == LAST_BEAT)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:
        if (out_valid && out_last) state_nxt = ST_DONE;
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      underrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (state_nxt == ST_READ) begin
            gnt     <= pick_gnt;
            out_sel <= pick_idx;
            cnt     <= '0;
          end
        ST_READ: begin
          if (fifo_rd_en) cnt <= cnt + 1'b1;
          if (fifo_empty) underrun <= 1'b1;
        end
        ST_DRAIN:
          if (state_nxt == ST_DONE) gnt <= '0;
        ST_DONE:
          rr_ptr <= (out_sel == IW'(NUM_REQ - 1)) ? '0 : out_sel + 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_last = fifo_rd_en && (cnt == LAST_BEAT);

  // With the FIFO output register on, data appears one cycle after rd_en.
  if (RD_LAT == 1) begin : g_lat1
    logic take_q, last_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        take_q <= 1'b0;
        last_q <= 1'b0;
      end else begin
        take_q <= fifo_rd_en;
        last_q <= rd_last;
      end
    end
    assign data_take = take_q;
    assign data_last = last_q;
  end else begin : g_lat0
    assign data_take = fifo_rd_en;
    assign data_last = rd_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= data_take;
      out_last  <= data_last;
      if (data_take) out_data <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_logfbe_frame_rd_arbiter.sv
// Directed bench for the LFBE frame read arbiter: one instance per read
// latency, each fed by a small behavioural FIFO holding incrementing words.
module tb_logfbe_frame_rd_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FL = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]    req0, req1, gnt0, gnt1;
  logic          rd_en0, rd_en1, empty0, empty1, force_empty;
  logic [AW:0]   lvl0, lvl1;
  logic [DW-1:0] rdata0, rdata1, odata0, odata1;
  logic          ov0, ov1, ol0, ol1, fd0, fd1, ur0, ur1;
  logic [1:0]    osel0, osel1;

  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  int wcnt0, wcnt1, rcnt0, rcnt1;
  int exp_w [2];
  int n_chk, n_pass;

  assign lvl0   = (AW + 1)'(wcnt0 - rcnt0);
  assign lvl1   = (AW + 1)'(wcnt1 - rcnt1);
  assign empty0 = (wcnt0 == rcnt0) || force_empty;
  assign empty1 = (wcnt1 == rcnt1);
  assign rdata0 = mem0[rcnt0[9:0]];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt0 <= 0;
    else if (rd_en0) rcnt0 <= rcnt0 + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rcnt1  <= 0;
      rdata1 <= '0;
    end else if (rd_en1) begin
      rdata1 <= mem1[rcnt1[9:0]];
      rcnt1  <= rcnt1 + 1;
    end

  logfbe_frame_rd_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                            .FRAME_LEN(FL), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .fifo_rd_en(rd_en0),
    .fifo_empty(empty0), .fifo_rd_water_level(lvl0), .fifo_rd_data(rdata0),
    .out_valid(ov0), .out_data(odata0), .out_sel(osel0), .out_last(ol0),
    .frame_done(fd0), .underrun(ur0));

  logfbe_frame_rd_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                            .FRAME_LEN(FL), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .fifo_rd_en(rd_en1),
    .fifo_empty(empty1), .fifo_rd_water_level(lvl1), .fifo_rd_data(rdata1),
    .out_valid(ov1), .out_data(odata1), .out_sel(osel1), .out_last(ol1),
    .frame_done(fd1), .underrun(ur1));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input int inst, input int n);
    for (int i = 0; i < n; i++) begin
      if (inst == 0) begin
        mem0[wcnt0[9:0]] = DW'(wcnt0);
        wcnt0++;
      end else begin
        mem1[wcnt1[9:0]] = DW'(wcnt1);
        wcnt1++;
      end
    end
  endtask

  int w_nrd, w_first_rd, w_last_rd, w_nval, w_first_val, w_last_idx, w_nlast;
  int w_last_cyc, w_done_cyc, w_data_err, w_stall_err;
  logic [3:0] w_gnt;
  logic [1:0] w_sel;

  // Follows one frame until frame_done (or budget expiry), logging timing.
  task automatic watch(input int inst, input int drop_at, input int stall_at);
    int stalled = 0;
    logic rd, ov, ol, fd;
    logic [DW-1:0] od;
    w_nrd = 0; w_first_rd = 0; w_last_rd = 0; w_nval = 0; w_first_val = 0;
    w_last_idx = 0; w_nlast = 0; w_last_cyc = 0; w_done_cyc = 0;
    w_data_err = 0; w_stall_err = 0; w_gnt = '0; w_sel = '0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      rd = (inst == 1) ? rd_en1 : rd_en0;
      ov = (inst == 1) ? ov1 : ov0;
      ol = (inst == 1) ? ol1 : ol0;
      fd = (inst == 1) ? fd1 : fd0;
      od = (inst == 1) ? odata1 : odata0;
      if (rd) begin
        if (w_nrd == 0) begin
          w_first_rd = cyc;
          w_gnt = (inst == 1) ? gnt1 : gnt0;
        end
        w_nrd++;
        w_last_rd = cyc;
        if (force_empty) w_stall_err++;
      end
      if (ov) begin
        if (w_nval == 0) begin
          w_first_val = cyc;
          w_sel = (inst == 1) ? osel1 : osel0;
        end
        w_nval++;
        if (od != DW'(exp_w[inst])) w_data_err++;
        exp_w[inst]++;
        if (ol) begin
          w_nlast++;
          w_last_idx = w_nval;
          w_last_cyc = cyc;
        end
      end
      if (fd) begin
        w_done_cyc = cyc;
        break;
      end
      if (drop_at > 0 && w_nrd >= drop_at) begin
        if (inst == 1) req1 = '0;
        else req0 = '0;
      end
      if (stall_at > 0 && w_nrd >= stall_at && stalled < 3) begin
        force_empty = 1'b1;
        stalled++;
      end else force_empty = 1'b0;
    end
    force_empty = 1'b0;
  endtask

  task automatic expect_frame(input logic [3:0] egnt, input int esel,
                              input int lat, input int span);
    chk("frame_done_seen", w_done_cyc > 0, 1);
    chk("gnt", w_gnt, egnt);
    chk("out_sel", w_sel, esel);
    chk("rd_count", w_nrd, FL);
    chk("rd_span", w_last_rd - w_first_rd, span);
    chk("valid_lat", w_first_val - w_first_rd, lat + 1);
    chk("valid_count", w_nval, FL);
    chk("data_order_errs", w_data_err, 0);
    chk("last_count", w_nlast, 1);
    chk("last_index", w_last_idx, FL);
    chk("done_after_last", w_done_cyc - w_last_cyc, 1);
  endtask

  initial begin
    int bad, k;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; req0 = '0; req1 = '0; force_empty = 1'b0;
    wcnt0 = 0; wcnt1 = 0; exp_w[0] = 0; exp_w[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_rd_en0", rd_en0, 0);
    chk("rst_valid0", ov0, 0);
    chk("rst_last0", ol0, 0);
    chk("rst_done0", fd0, 0);
    chk("rst_underrun0", ur0, 0);
    chk("rst_data0", odata0, 0);
    chk("rst_sel0", osel0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_valid1", ov1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, RD_LAT = 0.
    push(0, 40);
    req0 = 4'b0001;
    watch(0, -1, -1);
    req0 = '0;
    chk("t1_grant_latency", w_first_rd, 1);
    expect_frame(4'b0001, 0, 0, 39);
    @(negedge clk);
    chk("t1_gnt_cleared", gnt0, 0);
    chk("t1_underrun", ur0, 0);

    // Water level threshold.
    push(0, 39);
    req0 = 4'b0010;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt0 != 0 || rd_en0) bad++;
    end
    chk("no_grant_below_level", bad, 0);
    push(0, 1);
    watch(0, -1, -1);
    req0 = '0;
    chk("thr_grant_latency", w_first_rd, 1);
    expect_frame(4'b0010, 1, 0, 39);

    // RD_LAT = 1, request withdrawn after 5 beats.
    push(1, 40);
    req1 = 4'b0100;
    watch(1, 5, -1);
    expect_frame(4'b0100, 2, 1, 39);
    chk("lat1_underrun", ur1, 0);

    // Reset at beat 20 with rr_ptr at 2.
    push(0, 40);
    req0 = 4'b0100;
    k = 0;
    for (int g = 0; g < 100 && k < 20; g++) begin
      @(negedge clk);
      if (rd_en0) k++;
    end
    chk("reached_beat20", k, 20);
    chk("gnt_before_reset", gnt0, 4'b0100);
    rst_n = 1'b0;
    wcnt0 = 0; wcnt1 = 0; exp_w[0] = 0; exp_w[1] = 0; req0 = '0;
    #1;
    chk("arst_gnt", gnt0, 0);
    chk("arst_rd_en", rd_en0, 0);
    chk("arst_valid", ov0, 0);
    chk("arst_done", fd0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from rr_ptr = 0 with all requests held.
    push(0, 160);
    req0 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      watch(0, -1, -1);
      expect_frame(4'(1 << i), i, 0, 39);
    end
    push(0, 40);
    watch(0, -1, -1);
    req0 = '0;
    expect_frame(4'b0001, 0, 0, 39);

    // Three forced empty cycles mid-frame.
    push(0, 40);
    req0 = 4'b1000;
    watch(0, -1, 10);
    req0 = '0;
    expect_frame(4'b1000, 3, 0, 42);
    chk("stall_rd_en", w_stall_err, 0);
    chk("underrun_set", ur0, 1);
    repeat (5) @(negedge clk);
    chk("underrun_sticky", ur0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
